mod_inverse_unit: RTL and testbench

//  Sequential modular inverse: out = a^(Q-2) mod Q (Fermat), Q prime.

---
 rtl/mod_inverse_unit.sv | 123 ++++++++++++
 tb/tb_mod_inverse_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mod_inverse_unit.sv
// Modular inverse a^(Q-2) mod Q by square-and-multiply with in-cycle Barrett reduction; one op in flight.
// Latency: 21 cycles from input handshake to out_valid (2 for a == 0 mod Q); out_valid/data held until out_ready.
module mod_inverse_unit #(
    parameter int Q   = 3329,
    parameter int K   = 12,
    parameter int MU  = 5039,
    parameter int E_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_zero
);

    localparam int IDX_W = $clog2(E_W);
    localparam logic [E_W-1:0] E = E_W'(Q - 2);

    typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, DONE} state_t;

    state_t           state;
    logic [K-1:0]     acc;
    logic [K-1:0]     base;
    logic [K-1:0]     res;
    logic [IDX_W-1:0] idx;
    logic [K-1:0]     in_red;
    logic [K-1:0]     prod_red;
    logic [2*K-1:0]   prod;
    logic             unused_hi;

    // x < 2^(2K) leaves r below 3Q after the quotient estimate, so two corrections suffice.
    function automatic logic [K-1:0] barrett(input logic [2*K-1:0] x);
        logic [63:0] q1;
        logic [63:0] q2;
        logic [63:0] r;
        q1 = 64'(x) >> (K - 1);
        q2 = (q1 * 64'(MU)) >> (K + 1);
        r  = 64'(x) - q2 * 64'(Q);
        if (r >= 64'(Q)) r = r - 64'(Q);
        if (r >= 64'(Q)) r = r - 64'(Q);
        return r[K-1:0];
    endfunction

    assign unused_hi = ^in_data[31:2*K];
    assign in_red    = barrett(in_data[2*K-1:0]);
    assign prod      = (2*K)'(acc) * (2*K)'((state == SQR) ? acc : base);
    assign prod_red  = barrett(prod);
    assign out_data  = 32'(res);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            out_zero  <= 1'b0;
            acc       <= '0;
            base      <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        base     <= in_red;
                        in_ready <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (base == '0) begin
                        res      <= '0;
                        out_zero <= 1'b1;
                        state    <= DONE;
                    end else begin
                        acc      <= base;
                        idx      <= IDX_W'(E_W - 2);
                        out_zero <= 1'b0;
                        state    <= SQR;
                    end
                end
                SQR: begin
                    acc <= prod_red;
                    if (E[idx]) begin
                        state <= MUL;
                    end else if (idx == '0) begin
                        res       <= prod_red;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                MUL: begin
                    acc <= prod_red;
                    if (idx == '0) begin
                        res       <= prod_red;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= SQR;
                    end
                end
                DONE: begin
                    // The zero path arrives without out_valid and publishes one cycle later.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_inverse_unit.sv
// Randomized and directed checks of mod_inverse_unit against a brute-force inverse model.
module tb_mod_inverse_unit;

    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;

    int n_vec  = 0;
    int n_err  = 0;
    int xfers  = 0;

    mod_inverse_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) xfers <= xfers + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inverse found by exhaustive search: the x with a*x == 1 mod Q, or 0 when a == 0 mod Q.
    function automatic int ref_inv(input longint a);
        longint r;
        r = a % Q;
        if (r == 0) return 0;
        for (int x = 1; x < Q; x++) begin
            if ((r * x) % Q == 1) return x;
        end
        return -1;
    endfunction

    // Entered and left at a negedge. Captures result, zero flag and latency in cycles after T0.
    task automatic do_op(input logic [31:0] a, input int stall, input bit noise,
                         output logic [31:0] d, output logic z, output int lat);
        int cyc;
        in_data   = a;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = noise ? 1'($urandom) : 1'b0;
        if (noise) in_data = $urandom;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            check_eq("busy_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            cyc++;
            if (noise) begin
                in_valid = 1'($urandom);
                in_data  = $urandom;
            end
        end
        in_valid = 1'b0;
        lat = cyc;
        d   = out_data;
        z   = out_zero;
        if (!out_valid) begin
            check_eq("result_timeout", 32'(out_valid), 32'd1);
        end else begin
            repeat (stall) begin
                @(negedge clk);
                check_eq("stall_valid", 32'(out_valid), 32'd1);
                check_eq("stall_data", out_data, d);
                check_eq("stall_zero", 32'(out_zero), 32'(z));
                check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            check_eq("post_xfer_valid", 32'(out_valid), 32'd0);
            check_eq("post_xfer_in_ready", 32'(in_ready), 32'd1);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        z;
        int          lat;
        int          x0;
        logic [31:0] a;
        int          exp_d;
        int          cyc;
        logic [31:0] dir_a [6];
        int          dir_e [6];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_out_zero", 32'(out_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        dir_a = '{32'd2, 32'd17, 32'd3, 32'd1, 32'd3328, 32'hAB00_0002};
        dir_e = '{1665, 1175, 1110, 1, 3328, 1665};
        foreach (dir_a[i]) begin
            do_op(dir_a[i], 0, 1'b0, d, z, lat);
            check_eq("dir_data", d, 32'(dir_e[i]));
            check_eq("dir_zero", 32'(z), 32'd0);
            check_eq("dir_latency", 32'(lat), 32'd21);
        end

        do_op(32'd3329, 0, 1'b0, d, z, lat);
        check_eq("q_data", d, 32'd0);
        check_eq("q_zero", 32'(z), 32'd1);
        check_eq("q_latency", 32'(lat), 32'd2);
        do_op(32'd0, 1, 1'b0, d, z, lat);
        check_eq("zero_data", d, 32'd0);
        check_eq("zero_zero", 32'(z), 32'd1);
        check_eq("zero_latency", 32'(lat), 32'd2);
        do_op(32'd2, 0, 1'b0, d, z, lat);
        check_eq("after_zero_data", d, 32'd1665);
        check_eq("after_zero_zero", 32'(z), 32'd0);

        x0 = xfers;
        do_op(32'd6660, 10, 1'b1, d, z, lat);
        check_eq("stall_result", d, 32'd1665);
        check_eq("stall_xfers", 32'(xfers - x0), 32'd1);

        // Abort: reset sampled at the eighth edge after acceptance.
        in_data  = 32'd5;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd1);
        x0 = xfers;
        repeat (3) @(negedge clk);
        check_eq("abort_no_output", 32'(out_valid), 32'd0);
        do_op(32'd3, 0, 1'b0, d, z, lat);
        check_eq("abort_next_data", d, 32'd1110);
        check_eq("abort_xfers", 32'(xfers - x0), 32'd1);

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) a = {8'($urandom), 24'($urandom)};
            else a = {8'($urandom), 24'($urandom_range(1, Q - 1))};
            cyc = $urandom_range(0, 3);
            repeat (cyc) @(negedge clk);
            exp_d = ref_inv(longint'(a[23:0]));
            do_op(a, $urandom_range(0, 3), 1'b1, d, z, lat);
            check_eq("rand_data", d, 32'(exp_d));
            check_eq("rand_zero", 32'(z), 32'(exp_d == 0));
            if (exp_d != 0) begin
                check_eq("rand_product", 32'((longint'(a[23:0]) * longint'(d)) % Q), 32'd1);
                check_eq("rand_latency", 32'(lat), 32'd21);
            end else begin
                check_eq("rand_zero_latency", 32'(lat), 32'd2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
